// File: rtl/wishbone_rr_arbiter_if.sv
// Bundle of the NM master-side Wishbone ports and the single shared slave-side port.
// The arbiter uses the slave modport; whatever drives the masters and the target uses master.
interface wishbone_rr_arbiter_if #(
  parameter int unsigned NM         = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 3
);
  localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;

  logic [NM-1:0]            masters_cyc;
  logic [NM-1:0]            masters_stb;
  logic [NM-1:0]            masters_we;
  logic [NM*TAG_WIDTH-1:0]  masters_tag;
  logic [NM*SEL_WIDTH-1:0]  masters_sel;
  logic [NM*ADDR_WIDTH-1:0] masters_adr;
  logic [NM*DATA_WIDTH-1:0] masters_mosi;
  logic [NM*DATA_WIDTH-1:0] masters_miso;
  logic [NM-1:0]            masters_ack;
  logic [NM-1:0]            masters_err;

  logic                     slave_cyc;
  logic                     slave_stb;
  logic                     slave_we;
  logic [TAG_WIDTH-1:0]     slave_tag;
  logic [SEL_WIDTH-1:0]     slave_sel;
  logic [ADDR_WIDTH-1:0]    slave_adr;
  logic [DATA_WIDTH-1:0]    slave_mosi;
  logic [DATA_WIDTH-1:0]    slave_miso;
  logic                     slave_ack;
  logic                     slave_err;

  modport slave (
    input  masters_cyc, masters_stb, masters_we, masters_tag, masters_sel, masters_adr,
           masters_mosi, slave_miso, slave_ack, slave_err,
    output masters_miso, masters_ack, masters_err, slave_cyc, slave_stb, slave_we, slave_tag,
           slave_sel, slave_adr, slave_mosi
  );

  modport master (
    output masters_cyc, masters_stb, masters_we, masters_tag, masters_sel, masters_adr,
           masters_mosi, slave_miso, slave_ack, slave_err,
    input  masters_miso, masters_ack, masters_err, slave_cyc, slave_stb, slave_we, slave_tag,
           slave_sel, slave_adr, slave_mosi
  );
endinterface

// File: rtl/wishbone_rr_arbiter.sv
// Round-robin Wishbone arbiter with bus locking: a granted master owns the slave port until it
// drops cyc. A watchdog converts a stalled strobe into a one-cycle err so the bus cannot hang.
module wishbone_rr_arbiter #(
  parameter int unsigned NM         = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 3,
  parameter int unsigned TIMEOUT    = 256
) (
  input logic                  sys_clk,
  input logic                  sys_rst,
  wishbone_rr_arbiter_if.slave bus
);
  localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned GW = (NM > 1) ? $clog2(NM) : 1;
  localparam int unsigned WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {StIdle, StGranted} state_e;

  state_e        r_state, w_state;
  logic [GW-1:0] r_grant, w_grant;
  logic [GW-1:0] r_last, w_last;
  logic [WW-1:0] r_wdt, w_wdt;
  logic          r_abort, w_abort;

  logic          w_req;
  logic [GW-1:0] w_pick;
  int unsigned   w_best;
  logic          w_gcyc;
  logic          w_gstb;
  logic          w_fwd_cyc;
  logic          w_fwd_stb;

  // Distance of master idx from the slot right after last in the rotating priority order.
  function automatic int unsigned rr_dist(input int unsigned idx, input int unsigned last);
    return (idx + NM - last - 1) % NM;
  endfunction

  always_comb begin
    w_req  = |bus.masters_cyc;
    w_pick = '0;
    w_best = NM;
    for (int unsigned i = 0; i < NM; i++) begin
      if (bus.masters_cyc[i] && (rr_dist(i, 32'(r_last)) < w_best)) begin
        w_best = rr_dist(i, 32'(r_last));
        w_pick = GW'(i);
      end
    end
  end

  // Request mux and response demux, both steered by the registered grant.
  always_comb begin
    w_gcyc          = 1'b0;
    w_gstb          = 1'b0;
    w_fwd_cyc       = 1'b0;
    w_fwd_stb       = 1'b0;
    bus.slave_we    = 1'b0;
    bus.slave_tag   = '0;
    bus.slave_sel   = '0;
    bus.slave_adr   = '0;
    bus.slave_mosi  = '0;
    bus.masters_ack = '0;
    bus.masters_err = '0;
    bus.masters_miso = '0;
    if (r_state == StGranted) begin
      for (int unsigned i = 0; i < NM; i++) begin
        if (r_grant == GW'(i)) begin
          w_gcyc         = bus.masters_cyc[i];
          w_gstb         = bus.masters_stb[i];
          bus.slave_we   = bus.masters_we[i];
          bus.slave_tag  = bus.masters_tag[i*TAG_WIDTH +: TAG_WIDTH];
          bus.slave_sel  = bus.masters_sel[i*SEL_WIDTH +: SEL_WIDTH];
          bus.slave_adr  = bus.masters_adr[i*ADDR_WIDTH +: ADDR_WIDTH];
          bus.slave_mosi = bus.masters_mosi[i*DATA_WIDTH +: DATA_WIDTH];
          // An aborted or abandoned cycle must not see a stray ack from the target.
          bus.masters_ack[i] = bus.slave_ack & bus.masters_cyc[i] & ~r_abort;
          bus.masters_err[i] = bus.masters_cyc[i] & (bus.slave_err | r_abort);
          bus.masters_miso[i*DATA_WIDTH +: DATA_WIDTH] = bus.slave_miso;
        end
      end
      w_fwd_cyc = w_gcyc & ~r_abort;
      w_fwd_stb = w_gcyc & w_gstb & ~r_abort;
    end
    bus.slave_cyc = w_fwd_cyc;
    bus.slave_stb = w_fwd_stb;
  end

  always_comb begin
    w_state = r_state;
    w_grant = r_grant;
    w_last  = r_last;
    w_wdt   = '0;
    w_abort = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_req) begin
          w_state = StGranted;
          w_grant = w_pick;
          w_last  = w_pick;
        end
      end
      StGranted: begin
        if (!w_gcyc) begin
          w_state = StIdle;
        end else if ((TIMEOUT > 0) && w_fwd_stb && !bus.slave_ack && !bus.slave_err) begin
          if (r_wdt == WW'(TIMEOUT - 1)) begin
            w_abort = 1'b1;
          end else begin
            w_wdt = r_wdt + WW'(1);
          end
        end
      end
      default: w_state = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= StIdle;
      r_grant <= '0;
      r_last  <= GW'(NM - 1);
      r_wdt   <= '0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_state;
      r_grant <= w_grant;
      r_last  <= w_last;
      r_wdt   <= w_wdt;
      r_abort <= w_abort;
    end
  end

endmodule
